// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered read port, occupancy flags and sticky error flags.
// Read latency 1 cycle; full rejects writes unless a read is accepted the same cycle, empty rejects reads.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]       wptr_q, wptr_d;
  logic [ADDR_W:0]       rptr_q, rptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;
  logic                  overflow_q, underflow_q;
  logic                  rd_ok, wr_ok;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A full FIFO can still take a write when a read frees a slot in the same cycle.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + PTR_ONE;
    if (rd_ok) rptr_d = rptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_ok;
      if (wr_ok) mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
      // Reads see the word as it was before this edge's write.
      if (rd_ok) data_out_q <= mem_q[rptr_q[ADDR_W-1:0]];
      if (wr_en & ~wr_ok) overflow_q <= 1'b1;
      if (rd_en & ~rd_ok) underflow_q <= 1'b1;
    end
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at DATA_WIDTH=8, DEPTH=4.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int n_vec  = 0;
  int n_miss = 0;

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_rdv", 32'(rd_valid), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);

    // Fill A1..A4: almost_full from count 3, full at 4.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 8'hA1 + 8'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_empty", 32'(empty), 0);
      chk("fill_af", 32'(almost_full), (i >= 2) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 3) ? 1 : 0);
    end

    // Overflow: write to full without read.
    data_in = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    step();
    chk("ovf_sticky", 32'(overflow), 1);

    // Drain: A1..A4 in order with rd_valid pulses.
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_rdv", 32'(rd_valid), 1);
      chk("drain_dout", 32'(data_out), 32'(8'hA1 + 8'(i)));
      chk("drain_count", 32'(count), 32'(3 - i));
      chk("drain_ae", 32'(almost_empty), (i >= 2) ? 1 : 0);
    end
    rd_en = 1'b0;
    step();
    chk("pulse_end_rdv", 32'(rd_valid), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("hold_dout", 32'(data_out), 32'h A4);

    // Underflow: read from empty.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_rdv", 32'(rd_valid), 0);
    chk("unf_dout", 32'(data_out), 32'hA4);

    // Full with simultaneous read/write across pointer wrap.
    do_reset();
    chk("rst2_unf", 32'(underflow), 0);
    chk("rst2_ovf", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 8'h10 + 8'(i);
      step();
    end
    chk("refill_full", 32'(full), 1);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h14 + 8'(i);
      step();
      chk("rw_count", 32'(count), 4);
      chk("rw_ovf", 32'(overflow), 0);
      chk("rw_rdv", 32'(rd_valid), 1);
      chk("rw_dout", 32'(data_out), 32'(8'h10 + 8'(i)));
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rw_drain_dout", 32'(data_out), 32'(8'h18 + 8'(i)));
    end
    rd_en = 1'b0;
    step();
    chk("rw_drain_empty", 32'(empty), 1);
    chk("rw_unf", 32'(underflow), 0);

    // Empty with simultaneous write/read: read rejected, write kept.
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h55;
    step();
    wr_en = 1'b0;
    chk("er_unf", 32'(underflow), 1);
    chk("er_count", 32'(count), 1);
    chk("er_rdv", 32'(rd_valid), 0);
    step();
    rd_en = 1'b0;
    chk("er_dout", 32'(data_out), 32'h55);
    chk("er_rdv2", 32'(rd_valid), 1);
    chk("er_count2", 32'(count), 0);

    // Reset mid-operation with active requests.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = 8'h31 + 8'(i);
      step();
    end
    chk("pre_rst_count", 32'(count), 3);
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77; reset = 1'b1;
    step();
    reset = 1'b0; wr_en = 1'b0;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_dout", 32'(data_out), 0);
    chk("mrst_rdv", 32'(rd_valid), 0);
    chk("mrst_unf", 32'(underflow), 0);
    chk("mrst_af", 32'(almost_full), 0);
    chk("mrst_ae", 32'(almost_empty), 1);
    step();
    rd_en = 1'b0;
    chk("post_rst_rdv", 32'(rd_valid), 0);
    chk("post_rst_unf", 32'(underflow), 1);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_dout", 32'(data_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
